// File: rtl/door_motion_ctrl_if.sv
// rtl/door_motion_ctrl_if.sv - signal bundle between the door sequencer and its pins
// Ports (slave view, i.e. the controller):
//   i_ena          run enable; low freezes state/counter and gates the motor
//   i_req_open     open request, level sampled each enabled cycle
//   i_req_close    close request, level sampled each enabled cycle
//   i_limit_open   door fully open sensor
//   i_limit_closed door fully closed sensor
//   i_obstruct     doorway obstruction sensor
//   o_motor_open   motor drive, open direction
//   o_motor_close  motor drive, close direction
//   o_fault        latched fault indicator
//   o_state        current state code (debug / LEDs)
//   o_cnt          shared cycle counter (debug)
interface door_motion_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             i_ena;
  logic             i_req_open;
  logic             i_req_close;
  logic             i_limit_open;
  logic             i_limit_closed;
  logic             i_obstruct;
  logic             o_motor_open;
  logic             o_motor_close;
  logic             o_fault;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cnt;

  modport master (
    output i_ena, i_req_open, i_req_close, i_limit_open, i_limit_closed, i_obstruct,
    input  o_motor_open, o_motor_close, o_fault, o_state, o_cnt
  );

  modport slave (
    input  i_ena, i_req_open, i_req_close, i_limit_open, i_limit_closed, i_obstruct,
    output o_motor_open, o_motor_close, o_fault, o_state, o_cnt
  );
endinterface

// File: rtl/door_motion_ctrl.sv
// rtl/door_motion_ctrl.sv - door open/hold/close sequencer with timeouts and fault latch
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (state CLOSED, counter 0)
//   bus    door_motion_ctrl_if.slave: enable, requests, sensors in; motor, fault, state, cnt out
module door_motion_ctrl #(
  parameter int HOLD_CYCLES = 8,
  parameter int TRAVEL_MAX  = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  door_motion_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hold_restart;
  logic             w_limit_conflict;
  logic             w_counting;

  // Both limit switches closed at once is physically impossible: treat as a sensor failure.
  assign w_limit_conflict = bus.i_limit_open && bus.i_limit_closed;

  assign w_counting = (r_state == ST_OPENING) || (r_state == ST_OPEN) ||
                      (r_state == ST_CLOSING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLOSED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_restart = 1'b0;
    if (bus.i_ena) begin
      if (r_state != ST_FAULT && w_limit_conflict) begin
        w_state_nxt = ST_FAULT;
      end else begin
        case (r_state)
          ST_CLOSED: begin
            if (bus.i_req_open) w_state_nxt = ST_OPENING;
          end
          ST_OPENING: begin
            if (bus.i_limit_open)            w_state_nxt = ST_OPEN;
            else if (r_cnt == L_TRAVEL_LAST) w_state_nxt = ST_FAULT;
          end
          ST_OPEN: begin
            // Someone in the doorway or pressing open keeps the door parked open.
            if (bus.i_obstruct || bus.i_req_open) w_hold_restart = 1'b1;
            else if (bus.i_req_close)             w_state_nxt    = ST_CLOSING;
            else if (r_cnt == L_HOLD_LAST)        w_state_nxt    = ST_CLOSING;
          end
          ST_CLOSING: begin
            if (bus.i_obstruct || bus.i_req_open) w_state_nxt = ST_OPENING;
            else if (bus.i_limit_closed)          w_state_nxt = ST_CLOSED;
            else if (r_cnt == L_TRAVEL_LAST)      w_state_nxt = ST_FAULT;
          end
          ST_FAULT: begin
            w_state_nxt = ST_FAULT;
          end
          default: begin
            w_state_nxt = ST_FAULT;
          end
        endcase
      end
    end
  end

  // One counter serves hold and travel timing; any state change restarts it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.i_ena) begin
      if (w_state_nxt != r_state || w_hold_restart) begin
        w_cnt_nxt = '0;
      end else if (w_counting) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_nxt = '0;
      end
    end
  end

  // Motor drive decoded only from the state register and enable, so reset or a
  // dropped enable removes drive immediately and without glitches.
  assign bus.o_motor_open  = bus.i_ena && (r_state == ST_OPENING);
  assign bus.o_motor_close = bus.i_ena && (r_state == ST_CLOSING);
  assign bus.o_fault       = (r_state == ST_FAULT);
  assign bus.o_state       = r_state;
  assign bus.o_cnt         = r_cnt;

endmodule
